// File: rtl/led_pattern_engine_if.sv
// Control and LED-output bundle for the LED pattern engine.
// The master side drives run/speed/mode and observes the pattern outputs.
// The slave side is the engine itself.
interface led_pattern_engine_if #(
    parameter int NB_LEDS = 4
);
    logic               i_enable;
    logic [1:0]         i_speed;
    logic [1:0]         i_mode;
    logic [NB_LEDS-1:0] o_led;
    logic               o_tick;
    logic               o_dir;

    modport master (
        output i_enable,
        output i_speed,
        output i_mode,
        input  o_led,
        input  o_tick,
        input  o_dir
    );

    modport slave (
        input  i_enable,
        input  i_speed,
        input  i_mode,
        output o_led,
        output o_tick,
        output o_dir
    );
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern engine.
// A prescaler divides the clock by a speed-selected period. Each time the
// period expires, the LED pattern advances by one step (rotate left, rotate
// right, bounce or flash) and a one-cycle tick is emitted together with the
// new pattern. Changing the mode restarts the pattern from bit 0.
module led_pattern_engine #(
    parameter int NB_LEDS    = 4,
    parameter int NB_COUNTER = 32,
    parameter int LIMIT_0    = 2**22,
    parameter int LIMIT_1    = 2**23,
    parameter int LIMIT_2    = 2**24,
    parameter int LIMIT_3    = 2**25
) (
    input  logic                    clock,
    input  logic                    i_reset,
    led_pattern_engine_if.slave     bus
);

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'b00,
        MODE_ROTR   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FLASH  = 2'b11
    } mode_t;

    localparam logic [NB_COUNTER-1:0] LIMIT_M1_0 = NB_COUNTER'(LIMIT_0 - 1);
    localparam logic [NB_COUNTER-1:0] LIMIT_M1_1 = NB_COUNTER'(LIMIT_1 - 1);
    localparam logic [NB_COUNTER-1:0] LIMIT_M1_2 = NB_COUNTER'(LIMIT_2 - 1);
    localparam logic [NB_COUNTER-1:0] LIMIT_M1_3 = NB_COUNTER'(LIMIT_3 - 1);
    localparam logic [NB_LEDS-1:0]    LED_ONE    = NB_LEDS'(1);

    logic [NB_COUNTER-1:0] cnt_q, cnt_d;
    logic [NB_LEDS-1:0]    led_q, led_d;
    logic                  dir_q, dir_d;
    logic                  tick_q, tick_d;
    mode_t                 mode_q, mode_d;

    mode_t                 modeIn;
    logic [NB_COUNTER-1:0] limitM1;
    logic                  terminal;
    logic [NB_LEDS-1:0]    stepLed;
    logic                  stepDir;
    logic [NB_LEDS-1:0]    ledLeft;
    logic [NB_LEDS-1:0]    ledRight;

    assign modeIn   = mode_t'(bus.i_mode);
    assign ledLeft  = {led_q[NB_LEDS-2:0], 1'b0};
    assign ledRight = {1'b0, led_q[NB_LEDS-1:1]};

    // Select the current step period; >= compare lets a speed-up take effect at once.
    always_comb begin
        limitM1 = LIMIT_M1_0;
        unique case (bus.i_speed)
            2'd0: limitM1 = LIMIT_M1_0;
            2'd1: limitM1 = LIMIT_M1_1;
            2'd2: limitM1 = LIMIT_M1_2;
            2'd3: limitM1 = LIMIT_M1_3;
        endcase
    end

    assign terminal = (cnt_q >= limitM1);

    // Compute the pattern and direction that a step would produce in the current mode.
    always_comb begin
        stepLed = led_q;
        stepDir = dir_q;
        unique case (mode_q)
            MODE_ROTL:   stepLed = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
            MODE_ROTR:   stepLed = {led_q[0], led_q[NB_LEDS-1:1]};
            MODE_BOUNCE: begin
                if (!dir_q) begin
                    if (led_q[NB_LEDS-1]) begin
                        stepDir = 1'b1;
                        stepLed = ledRight;
                    end else begin
                        stepLed = ledLeft;
                    end
                end else begin
                    if (led_q[0]) begin
                        stepDir = 1'b0;
                        stepLed = ledLeft;
                    end else begin
                        stepLed = ledRight;
                    end
                end
            end
            MODE_FLASH:  stepLed = ~led_q;
        endcase
        // An all-dark pattern would never move again in the shifting modes.
        if ((mode_q != MODE_FLASH) && (led_q == '0)) begin
            stepLed = LED_ONE;
        end
    end

    // Next-state selection: mode change beats freeze, freeze beats stepping.
    always_comb begin
        cnt_d  = cnt_q;
        led_d  = led_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        mode_d = mode_q;
        if (modeIn != mode_q) begin
            cnt_d  = '0;
            led_d  = LED_ONE;
            dir_d  = 1'b0;
            mode_d = modeIn;
        end else if (bus.i_enable) begin
            if (terminal) begin
                cnt_d  = '0;
                led_d  = stepLed;
                dir_d  = stepDir;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + NB_COUNTER'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            cnt_q  <= '0;
            led_q  <= LED_ONE;
            dir_q  <= 1'b0;
            tick_q <= 1'b0;
            mode_q <= modeIn;
        end else begin
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
            mode_q <= mode_d;
        end
    end

    assign bus.o_led  = led_q;
    assign bus.o_tick = tick_q;
    assign bus.o_dir  = dir_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Testbench for led_pattern_engine.
// Expected step results are queued as stimulus is applied; a monitor pops
// one entry per observed tick and compares pattern and direction.
module tb_led_pattern_engine;

    localparam int NB_LEDS = 4;

    typedef struct {
        logic [NB_LEDS-1:0] led;
        logic               dir;
    } exp_t;

    logic clock   = 1'b0;
    logic i_reset = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t sbq[$];

    led_pattern_engine_if #(.NB_LEDS(NB_LEDS)) bus ();

    led_pattern_engine #(
        .NB_LEDS    (NB_LEDS),
        .NB_COUNTER (8),
        .LIMIT_0    (4),
        .LIMIT_1    (8),
        .LIMIT_2    (5),
        .LIMIT_3    (3)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] speed, input logic [1:0] mode);
        bus.i_enable = en;
        bus.i_speed  = speed;
        bus.i_mode   = mode;
    endtask

    task automatic pushExp(input logic [NB_LEDS-1:0] led, input logic dir);
        exp_t e;
        e.led = led;
        e.dir = dir;
        sbq.push_back(e);
    endtask

    task automatic stepClk();
        @(posedge clock);
        #3;
    endtask

    // Wait for the next tick and check how many edges it took.
    task automatic waitTick(input string tag, input int expGap);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 40) begin
            stepClk();
            n++;
            if (bus.o_tick === 1'b1) seen = 1'b1;
        end
        checkOutput(tag, 32'(n), 32'(expGap));
    endtask

    // Tick monitor: every tick must match the next queued step result.
    always @(posedge clock) begin : monitor
        exp_t e;
        #2;
        if (bus.o_tick === 1'b1) begin
            compared++;
            assert (sbq.size() > 0) else begin
                mismatched++;
                $error("[TB] FAIL unexpected_tick: observed tick with led %b, expected no tick", bus.o_led);
            end
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput("tick_led", 32'(bus.o_led), 32'(e.led));
                checkOutput("tick_dir", 32'(bus.o_dir), 32'(e.dir));
            end
        end
    end

    // Directed sequence of scenarios.
    initial begin
        applyStimulus(1'b1, 2'd0, 2'b00);
        i_reset = 1'b0;
        stepClk();
        stepClk();
        checkOutput("reset_led", 32'(bus.o_led), 32'h1);
        checkOutput("reset_dir", 32'(bus.o_dir), 32'h0);
        checkOutput("reset_tick", 32'(bus.o_tick), 32'h0);

        // Rotate left, period 4.
        i_reset = 1'b1;
        pushExp(4'b0010, 1'b0);
        pushExp(4'b0100, 1'b0);
        pushExp(4'b1000, 1'b0);
        pushExp(4'b0001, 1'b0);
        for (int k = 0; k < 4; k++) waitTick($sformatf("rotl_gap%0d", k), 4);

        // Bounce from a fresh pattern.
        applyStimulus(1'b1, 2'd0, 2'b10);
        stepClk();
        checkOutput("bounce_start_led", 32'(bus.o_led), 32'h1);
        checkOutput("bounce_start_dir", 32'(bus.o_dir), 32'h0);
        checkOutput("bounce_start_tick", 32'(bus.o_tick), 32'h0);
        pushExp(4'b0010, 1'b0);
        pushExp(4'b0100, 1'b0);
        pushExp(4'b1000, 1'b0);
        pushExp(4'b0100, 1'b1);
        pushExp(4'b0010, 1'b1);
        pushExp(4'b0001, 1'b1);
        pushExp(4'b0010, 1'b0);
        pushExp(4'b0100, 1'b0);
        pushExp(4'b1000, 1'b0);
        pushExp(4'b0100, 1'b1);
        for (int k = 0; k < 10; k++) waitTick($sformatf("bounce_gap%0d", k), 4);

        // Reset mid-count while bouncing back at 0100.
        stepClk();
        stepClk();
        i_reset = 1'b0;
        stepClk();
        checkOutput("midreset_led", 32'(bus.o_led), 32'h1);
        checkOutput("midreset_dir", 32'(bus.o_dir), 32'h0);
        checkOutput("midreset_tick", 32'(bus.o_tick), 32'h0);
        i_reset = 1'b1;
        pushExp(4'b0010, 1'b0);
        waitTick("midreset_gap", 4);

        // Slow speed, then speed up once the count has passed the fast limit.
        applyStimulus(1'b1, 2'd1, 2'b00);
        stepClk();
        checkOutput("speed_mode_led", 32'(bus.o_led), 32'h1);
        for (int k = 0; k < 6; k++) begin
            stepClk();
            checkOutput($sformatf("speed_notick%0d", k), 32'(bus.o_tick), 32'h0);
        end
        applyStimulus(1'b1, 2'd0, 2'b00);
        pushExp(4'b0010, 1'b0);
        waitTick("speedup_gap", 1);
        pushExp(4'b0100, 1'b0);
        waitTick("speedup_period", 4);

        // Flash toggles, then a mode change restarts everything.
        applyStimulus(1'b1, 2'd0, 2'b11);
        stepClk();
        checkOutput("flash_start_led", 32'(bus.o_led), 32'h1);
        checkOutput("flash_start_tick", 32'(bus.o_tick), 32'h0);
        pushExp(4'b1110, 1'b0);
        pushExp(4'b0001, 1'b0);
        pushExp(4'b1110, 1'b0);
        for (int k = 0; k < 3; k++) waitTick($sformatf("flash_gap%0d", k), 4);
        applyStimulus(1'b1, 2'd0, 2'b00);
        stepClk();
        checkOutput("flash_exit_led", 32'(bus.o_led), 32'h1);
        checkOutput("flash_exit_dir", 32'(bus.o_dir), 32'h0);
        checkOutput("flash_exit_tick", 32'(bus.o_tick), 32'h0);
        pushExp(4'b0010, 1'b0);
        waitTick("flash_exit_gap", 4);

        // Rotate right.
        applyStimulus(1'b1, 2'd0, 2'b01);
        stepClk();
        checkOutput("rotr_start_led", 32'(bus.o_led), 32'h1);
        pushExp(4'b1000, 1'b0);
        pushExp(4'b0100, 1'b0);
        for (int k = 0; k < 2; k++) waitTick($sformatf("rotr_gap%0d", k), 4);

        // Freeze at count 2 for 10 cycles, then resume.
        stepClk();
        stepClk();
        applyStimulus(1'b0, 2'd0, 2'b01);
        for (int k = 0; k < 10; k++) begin
            stepClk();
            checkOutput($sformatf("freeze_tick%0d", k), 32'(bus.o_tick), 32'h0);
            checkOutput($sformatf("freeze_led%0d", k), 32'(bus.o_led), 32'h4);
        end
        applyStimulus(1'b1, 2'd0, 2'b01);
        pushExp(4'b0010, 1'b0);
        waitTick("resume_gap", 2);

        // Remaining speed codes.
        applyStimulus(1'b1, 2'd3, 2'b01);
        pushExp(4'b0001, 1'b0);
        waitTick("speed3_gap", 3);
        applyStimulus(1'b1, 2'd2, 2'b01);
        pushExp(4'b1000, 1'b0);
        waitTick("speed2_gap", 5);

        // Mode change while frozen still restarts the pattern.
        applyStimulus(1'b0, 2'd2, 2'b00);
        stepClk();
        checkOutput("frozen_mode_led", 32'(bus.o_led), 32'h1);
        checkOutput("frozen_mode_tick", 32'(bus.o_tick), 32'h0);
        stepClk();
        stepClk();
        checkOutput("frozen_hold_led", 32'(bus.o_led), 32'h1);
        applyStimulus(1'b1, 2'd0, 2'b00);
        pushExp(4'b0010, 1'b0);
        waitTick("frozen_mode_gap", 4);

        stepClk();
        checkOutput("queue_drained", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
